// File: rtl/rpath_packet_writer.sv
// rpath_packet_writer
// Moves a counted stream of 32-bit source words into the FX3 bus read path,
// one bus-sized packet per channel activation, until the requested word
// count is exhausted, then pulses o_done_stb.
// Optional build macro: RPATH_ROUND_ROBIN_EN -- alternate between the two
// read channels when both are ready (default build: ch0 always wins).
module rpath_packet_writer #(
    parameter int SIZE_WIDTH  = 24,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start_stb,
    input  logic [COUNT_WIDTH-1:0] i_total_count,
    output logic                   o_busy,
    output logic                   o_done_stb,
    input  logic [31:0]            i_src_data,
    input  logic                   i_src_valid,
    output logic                   o_src_ready,
    input  logic [1:0]             i_rpath_ready,
    output logic [1:0]             o_rpath_activate,
    input  logic [SIZE_WIDTH-1:0]  i_rpath_size,
    output logic [31:0]            o_rpath_data,
    output logic                   o_rpath_strobe
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CH,
        ACTIVE,
        RELEASE
    } state_t;

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic [SIZE_WIDTH-1:0]  packet_left_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   src_ready_q;
    logic [1:0]             activate_q;
    logic [31:0]            data_q;
    logic                   strobe_q;

    logic [COUNT_WIDTH-1:0] remaining_d;
    logic [SIZE_WIDTH-1:0]  packet_left_d;
    logic                   accept;
    logic                   sel_ch_d;

`ifdef RPATH_ROUND_ROBIN_EN
    logic                   last_ch_q;
`endif

    // Handshake and saturating decrements of both word counters
    always_comb begin
        accept        = src_ready_q & i_src_valid;
        remaining_d   = (remaining_q != '0) ? remaining_q - COUNT_WIDTH'(1) : '0;
        packet_left_d = (packet_left_q != '0) ? packet_left_q - SIZE_WIDTH'(1) : '0;
    end

    // Channel choice among the ready read channels
    always_comb begin
`ifdef RPATH_ROUND_ROBIN_EN
        if (i_rpath_ready == 2'b11) begin
            sel_ch_d = ~last_ch_q;
        end else begin
            sel_ch_d = i_rpath_ready[1];
        end
`else
        sel_ch_d = ~i_rpath_ready[0];
`endif
    end

    // Transfer sequencer with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            packet_left_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            src_ready_q   <= 1'b0;
            activate_q    <= 2'b00;
            data_q        <= '0;
            strobe_q      <= 1'b0;
`ifdef RPATH_ROUND_ROBIN_EN
            last_ch_q     <= 1'b1;
`endif
        end else begin
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start_stb) begin
                        if (i_total_count != '0) begin
                            remaining_q <= i_total_count;
                            busy_q      <= 1'b1;
                            state_q     <= WAIT_CH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                WAIT_CH: begin
                    if (i_rpath_ready != 2'b00) begin
                        packet_left_q <= i_rpath_size;
`ifdef RPATH_ROUND_ROBIN_EN
                        last_ch_q     <= sel_ch_d;
`endif
                        if (i_rpath_size != '0) begin
                            activate_q  <= sel_ch_d ? 2'b10 : 2'b01;
                            src_ready_q <= 1'b1;
                            state_q     <= ACTIVE;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        data_q        <= i_src_data;
                        strobe_q      <= 1'b1;
                        remaining_q   <= remaining_d;
                        packet_left_q <= packet_left_d;
                        if ((remaining_d == '0) || (packet_left_d == '0)) begin
                            src_ready_q <= 1'b0;
                            activate_q  <= 2'b00;
                            state_q     <= RELEASE;
                        end
                    end else if (!src_ready_q) begin
                        activate_q <= 2'b00;
                        state_q    <= RELEASE;
                    end
                end
                RELEASE: begin
                    activate_q <= 2'b00;
                    if (remaining_q != '0) begin
                        state_q <= WAIT_CH;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy           = busy_q;
    assign o_done_stb       = done_q;
    assign o_src_ready      = src_ready_q;
    assign o_rpath_activate = activate_q;
    assign o_rpath_data     = data_q;
    assign o_rpath_strobe   = strobe_q;

endmodule

// File: tb/tb_rpath_packet_writer.sv
// Self-checking bench for rpath_packet_writer.
// Accepted source words go into a scoreboard queue and are compared against
// o_rpath_data as strobes appear; activations, done timing and busy span
// are checked per transfer. Honours RPATH_ROUND_ROBIN_EN for channel order.
module tb_rpath_packet_writer;

    logic        clk;
    logic        rst;
    logic        i_start_stb;
    logic [31:0] i_total_count;
    logic        o_busy;
    logic        o_done_stb;
    logic [31:0] i_src_data;
    logic        i_src_valid;
    logic        o_src_ready;
    logic [1:0]  i_rpath_ready;
    logic [1:0]  o_rpath_activate;
    logic [23:0] i_rpath_size;
    logic [31:0] o_rpath_data;
    logic        o_rpath_strobe;

    int          checks;
    int          failures;
    int          cycleNum;
    int          strobeCount;
    int          doneCount;
    int          doneCycle;
    int          lastReleaseCycle;
    logic [1:0]  prevAct;
    bit          toggleMode;
    logic [31:0] scoreboard[$];
    int          actLog[$];

    rpath_packet_writer #(
        .SIZE_WIDTH (24),
        .COUNT_WIDTH(32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start_stb     (i_start_stb),
        .i_total_count   (i_total_count),
        .o_busy          (o_busy),
        .o_done_stb      (o_done_stb),
        .i_src_data      (i_src_data),
        .i_src_valid     (i_src_valid),
        .o_src_ready     (o_src_ready),
        .i_rpath_ready   (i_rpath_ready),
        .o_rpath_activate(o_rpath_activate),
        .i_rpath_size    (i_rpath_size),
        .o_rpath_data    (o_rpath_data),
        .o_rpath_strobe  (o_rpath_strobe)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ
    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycleNum);
        end
    endtask

    // Advances one clock, predicting the strobe from the handshake seen before the edge
    task automatic stepCycle();
        logic        willAccept;
        logic [31:0] expWord;
        willAccept = i_src_valid && o_src_ready;
        if (willAccept) scoreboard.push_back(i_src_data);
        @(posedge clk);
        @(negedge clk);
        cycleNum++;
        checkOutput("strobe_vs_accept", o_rpath_strobe, willAccept);
        if (o_rpath_strobe) begin
            strobeCount++;
            if (scoreboard.size() == 0) begin
                checkOutput("scoreboard_underflow", 1, 0);
            end else begin
                expWord = scoreboard.pop_front();
                checkOutput("data_order", o_rpath_data, expWord);
            end
        end
        checkOutput("activate_onehot", (o_rpath_activate != 2'b11), 1);
        if (prevAct == 2'b00 && o_rpath_activate != 2'b00) actLog.push_back(o_rpath_activate[1] ? 1 : 0);
        if (prevAct != 2'b00 && o_rpath_activate == 2'b00) lastReleaseCycle = cycleNum;
        if (o_done_stb) begin
            doneCount++;
            doneCycle = cycleNum;
        end
        prevAct = o_rpath_activate;
        if (willAccept) i_src_data = $urandom();
        if (toggleMode) i_src_valid = ~i_src_valid;
    endtask

    // Runs one whole transfer and checks its shape against the expected packetisation
    task automatic applyStimulus(input int count, input int size, input logic [1:0] ready,
                                 input bit toggle, input bit alternate);
        int npk;
        int expCh;
        i_total_count    = count;
        i_rpath_size     = size[23:0];
        i_rpath_ready    = ready;
        toggleMode       = toggle;
        i_src_valid      = 1'b1;
        strobeCount      = 0;
        doneCount        = 0;
        doneCycle        = -1;
        lastReleaseCycle = -1;
        actLog.delete();
        i_start_stb = 1'b1;
        stepCycle();
        i_start_stb = 1'b0;
        if (count == 0) begin
            checkOutput("zero_done", o_done_stb, 1);
            checkOutput("zero_busy", o_busy, 0);
            stepCycle();
            checkOutput("zero_done_width", o_done_stb, 0);
            checkOutput("zero_busy_after", o_busy, 0);
            checkOutput("zero_no_activation", actLog.size(), 0);
            return;
        end
        checkOutput("busy_rise", o_busy, 1);
        for (int i = 0; i < 2000 && doneCount == 0; i++) begin
            stepCycle();
            if (!o_done_stb) checkOutput("busy_span", o_busy, 1);
            if (strobeCount == count && !o_done_stb) checkOutput("ready_after_last", o_src_ready, 0);
        end
        if (doneCount == 0) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            checkOutput("busy_fall", o_busy, 0);
            checkOutput("done_after_release", doneCycle, lastReleaseCycle + 1);
        end
        stepCycle();
        checkOutput("done_width", o_done_stb, 0);
        checkOutput("src_ready_idle", o_src_ready, 0);
        checkOutput("strobe_total", strobeCount, count);
        checkOutput("scoreboard_empty", scoreboard.size(), 0);
        npk = (count + size - 1) / size;
        checkOutput("packet_count", actLog.size(), npk);
        for (int p = 0; p < actLog.size() && p < npk; p++) begin
            if (ready == 2'b10) expCh = 1;
            else if (ready == 2'b01) expCh = 0;
            else expCh = alternate ? (p % 2) : 0;
            checkOutput("channel_order", actLog[p], expCh);
        end
    endtask

    // Checks every output against its reset value
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_done"}, o_done_stb, 0);
        checkOutput({tag, "_src_ready"}, o_src_ready, 0);
        checkOutput({tag, "_activate"}, o_rpath_activate, 0);
        checkOutput({tag, "_strobe"}, o_rpath_strobe, 0);
        checkOutput({tag, "_data"}, o_rpath_data, 0);
    endtask

    // Applies a clean reset pulse between negative edges
    task automatic resetPulse();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        scoreboard.delete();
        prevAct = 2'b00;
    endtask

    // Main test sequence
    initial begin
        checks        = 0;
        failures      = 0;
        cycleNum      = 0;
        prevAct       = 2'b00;
        toggleMode    = 1'b0;
        rst           = 1'b1;
        i_start_stb   = 1'b0;
        i_total_count = '0;
        i_src_data    = $urandom();
        i_src_valid   = 1'b0;
        i_rpath_ready = 2'b00;
        i_rpath_size  = '0;
        @(negedge clk);
        @(negedge clk);
        checkResetValues("por");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] two full ch0 packets");
        applyStimulus(8, 4, 2'b01, 1'b0, 1'b0);

        $display("[TB] packet clipped by remaining count");
        applyStimulus(3, 128, 2'b01, 1'b0, 1'b0);

        $display("[TB] zero-length transfer");
        applyStimulus(0, 4, 2'b01, 1'b0, 1'b0);

        $display("[TB] source valid toggling");
        applyStimulus(6, 6, 2'b01, 1'b1, 1'b0);

        $display("[TB] only ch1 ready");
        applyStimulus(5, 2, 2'b10, 1'b0, 1'b0);

        $display("[TB] both channels ready");
        resetPulse();
`ifdef RPATH_ROUND_ROBIN_EN
        applyStimulus(16, 4, 2'b11, 1'b0, 1'b1);
`else
        applyStimulus(16, 4, 2'b11, 1'b0, 1'b0);
`endif

        $display("[TB] reset during second word of a packet");
        i_total_count = 8;
        i_rpath_size  = 4;
        i_rpath_ready = 2'b01;
        toggleMode    = 1'b0;
        i_src_valid   = 1'b1;
        strobeCount   = 0;
        i_start_stb   = 1'b1;
        stepCycle();
        i_start_stb = 1'b0;
        for (int i = 0; i < 50 && strobeCount < 1; i++) stepCycle();
        if (strobeCount < 1) checkOutput("first_strobe_timeout", 0, 1);
        checkOutput("mid_busy_before_reset", o_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("async");
        @(negedge clk);
        checkResetValues("held");
        rst = 1'b0;
        scoreboard.delete();
        prevAct = 2'b00;
        applyStimulus(5, 4, 2'b01, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
